cnn_window_counter: RTL and testbench
=====================================

// Module: cnn_window_counter
// PURPOSE
//  Three-level nested loop counter (col -> row -> channel) with runtime bounds.
//  Column and row steps are set by strides. A start/done handshake frames each pass.
//  Drives the feature-map / kernel address generators of the conv engine.
//  Replaces chains of single-level pulse counters with one registered block.
// PARAMETERS
//  width_p       8  bit width of every index output and bound input
//  col_stride_p  1  column step per advance (>=1)
//  row_stride_p  1  row step per column wrap (>=1)
// PORTS
//  clk_i        in   1        rising-edge clock
//  reset_i      in   1        synchronous, active-high reset
//  start_i      in   1        begin a pass; sampled only in IDLE
//  cfg_cols_i   in   width_p  column bound (exclusive), latched on accepted start
//  cfg_rows_i   in   width_p  row bound (exclusive), latched on accepted start
//  cfg_chans_i  in   width_p  channel bound (exclusive), latched on accepted start
//  en_i         in   1        advance enable; 0 = stall, hold tuple
//  busy_o       out  1        1 while in RUN
//  valid_o      out  1        tuple on col/row/chan_o is live (= busy_o)
//  col_o        out  width_p  current column index
//  row_o        out  width_p  current row index
//  chan_o       out  width_p  current channel index
//  last_o       out  1        current tuple is the final one of the pass (comb. from state)
//  row_wrap_o   out  1        1-cycle pulse: column wrapped on previous advance
//  done_o       out  1        1-cycle pulse: final tuple was accepted on previous cycle
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched bounds 0. Reset beats every other input.
//  Reset mid-pass aborts the pass: no done_o pulse.
//  States: IDLE, RUN. Every output listed above is a register, except last_o.
//  IDLE, start_i=1, all bounds nonzero: latch bounds; indices=0; go to RUN next cycle.
//  IDLE, start_i=1, any bound 0: stay IDLE; done_o=1 the next cycle; valid_o never rises.
//  RUN, en_i=0: hold all indices; row_wrap_o=0; done_o=0.
//  RUN, en_i=1 advance (next-value sums computed in width_p+1 bits, no overflow):
//   col wraps when col+col_stride_p >= cols. On wrap: col<=0, row_wrap_o<=1.
//   Otherwise: col<=col+col_stride_p.
//   row wraps (only on col wrap) when row+row_stride_p >= rows. On wrap: row<=0, chan<=chan+1.
//   Otherwise, on col wrap: row<=row+row_stride_p.
//   last_o = col and row both at wrap point AND chan==chans-1.
//   Advance with last_o=1: indices<=0, state<=IDLE, done_o<=1, row_wrap_o<=1.
//  start_i in RUN is ignored; its bounds are not latched.
//  start_i in the cycle done_o is high (IDLE) is accepted normally: back-to-back passes.
//  Bound changes during RUN have no effect; only latched copies are used.
//  Tuples per pass = ceil(cols/col_stride_p) * ceil(rows/row_stride_p) * chans.
// TESTING
//  T1 cols=3,rows=2,chans=2,en=1: tuples (c,r,ch) run (0,0,0)(1,0,0)(2,0,0)(0,1,0)..(2,1,1).
//     That is 12 tuples. last_o=1 only on (2,1,1); done_o pulses the next cycle; busy_o drops.
//  T2 col_stride_p=2, cols=5,rows=1,chans=1: col 0,2,4, then done.
//     row_wrap_o pulses once, together with done_o.
//  T3 T1 config with en_i toggled 1,0,0,1: indices hold while en_i=0.
//     Still exactly 12 advances; done_o is delayed by the stall cycles.
//  T4 start_i held high through a pass, cfg changed mid-pass: first pass unaffected.
//     A second pass begins right after done_o and uses the new cfg.
//  T5 cfg_rows_i=0: done_o=1 the cycle after start; busy_o and valid_o stay 0.
//  T6 reset_i=1 at tuple (1,1,0) of T1: next cycle IDLE, outputs 0, no done_o pulse.
//     A fresh start_i restarts from (0,0,0).

Source files
------------

// File: rtl/cnn_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : cnn_window_counter
// Description : Three-level nested loop counter (col -> row -> channel) with
//               runtime bounds and compile-time column/row strides. Each pass
//               is framed by a start/done handshake. The counter feeds the
//               feature-map and kernel address generators of the conv engine.
//
// Ports
//   clk_i        in   1        rising-edge clock
//   reset_i      in   1        synchronous, active-high reset
//   start_i      in   1        begin a pass (sampled only in IDLE)
//   cfg_cols_i   in   width_p  column bound (exclusive), latched on start
//   cfg_rows_i   in   width_p  row bound (exclusive), latched on start
//   cfg_chans_i  in   width_p  channel bound (exclusive), latched on start
//   en_i         in   1        advance enable; 0 holds the current tuple
//   busy_o       out  1        high while a pass is running
//   valid_o      out  1        tuple on col_o/row_o/chan_o is live
//   col_o        out  width_p  current column index
//   row_o        out  width_p  current row index
//   chan_o       out  width_p  current channel index
//   last_o       out  1        current tuple is the final one of the pass
//   row_wrap_o   out  1        pulse: column wrapped on the previous advance
//   done_o       out  1        pulse: final tuple accepted on previous cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_window_counter #(
    parameter int width_p      = 8,
    parameter int col_stride_p = 1,
    parameter int row_stride_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [width_p-1:0] cfg_cols_i,
    input  logic [width_p-1:0] cfg_rows_i,
    input  logic [width_p-1:0] cfg_chans_i,
    input  logic               en_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [width_p-1:0] col_o,
    output logic [width_p-1:0] row_o,
    output logic [width_p-1:0] chan_o,
    output logic               last_o,
    output logic               row_wrap_o,
    output logic               done_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Steps are widened by one bit so index + stride can never overflow
    // before it is compared against the bound.
    localparam logic [width_p:0]   C_COL_STEP = (width_p+1)'(col_stride_p);
    localparam logic [width_p:0]   C_ROW_STEP = (width_p+1)'(row_stride_p);
    localparam logic [width_p-1:0] C_ONE      = width_p'(1);
    localparam logic [width_p-1:0] C_ZERO     = '0;

    logic [0:0]         r_state;
    logic               r_busy;
    logic [width_p-1:0] r_col;
    logic [width_p-1:0] r_row;
    logic [width_p-1:0] r_chan;
    logic [width_p-1:0] r_cols;
    logic [width_p-1:0] r_rows;
    logic [width_p-1:0] r_chans;
    logic               r_row_wrap;
    logic               r_done;

    logic [width_p:0]   w_col_sum;
    logic [width_p:0]   w_row_sum;
    logic               w_col_wrap;
    logic               w_row_wrap;
    logic               w_chan_last;
    logic               w_any_zero;
    logic               w_last;

    always_comb begin
        w_col_sum   = {1'b0, r_col} + C_COL_STEP;
        w_row_sum   = {1'b0, r_row} + C_ROW_STEP;
        w_col_wrap  = (w_col_sum >= {1'b0, r_cols});
        w_row_wrap  = (w_row_sum >= {1'b0, r_rows});
        w_chan_last = (r_chan == (r_chans - C_ONE));
        w_any_zero  = (cfg_cols_i == C_ZERO) || (cfg_rows_i == C_ZERO) ||
                      (cfg_chans_i == C_ZERO);
        // Gated by RUN so stale or zero bounds in IDLE never flag a last tuple.
        w_last      = (r_state == S_RUN) && w_col_wrap && w_row_wrap && w_chan_last;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_chan     <= '0;
            r_cols     <= '0;
            r_rows     <= '0;
            r_chans    <= '0;
            r_row_wrap <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Both flags are single-cycle pulses unless re-asserted below.
            r_row_wrap <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_any_zero) begin
                            // Empty pass: report completion without running.
                            r_done <= 1'b1;
                        end else begin
                            r_cols  <= cfg_cols_i;
                            r_rows  <= cfg_rows_i;
                            r_chans <= cfg_chans_i;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_chan  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (en_i) begin
                        if (w_last) begin
                            r_col      <= '0;
                            r_row      <= '0;
                            r_chan     <= '0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_row_wrap <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (w_col_wrap) begin
                            r_col      <= '0;
                            r_row_wrap <= 1'b1;
                            if (w_row_wrap) begin
                                r_row  <= '0;
                                r_chan <= r_chan + C_ONE;
                            end else begin
                                r_row  <= w_row_sum[width_p-1:0];
                            end
                        end else begin
                            r_col <= w_col_sum[width_p-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign valid_o    = r_busy;
    assign col_o      = r_col;
    assign row_o      = r_row;
    assign chan_o     = r_chan;
    assign last_o     = w_last;
    assign row_wrap_o = r_row_wrap;
    assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cnn_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_window_counter
// Description : Self-checking bench for cnn_window_counter. A vector table
//               covers reset, a full 3x2x2 pass, an empty pass and a reset
//               abort; hand-written sequences cover stalls, start held high
//               with mid-pass config changes, and a column stride of 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_window_counter;

    localparam int W = 8;

    typedef struct {
        logic       rst;
        logic       start;
        logic       en;
        logic [7:0] cols;
        logic [7:0] rows;
        logic [7:0] chans;
        logic       busy;
        logic [7:0] col;
        logic [7:0] row;
        logic [7:0] chan;
        logic       last;
        logic       rw;
        logic       done;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         en;
    logic [W-1:0] cols;
    logic [W-1:0] rows;
    logic [W-1:0] chans;

    logic         busy1, valid1, last1, rw1, done1;
    logic [W-1:0] col1, row1, chan1;
    logic         busy2, valid2, last2, rw2, done2;
    logic [W-1:0] col2, row2, chan2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cnn_window_counter #(.width_p(W), .col_stride_p(1), .row_stride_p(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .start_i(start),
        .cfg_cols_i(cols), .cfg_rows_i(rows), .cfg_chans_i(chans), .en_i(en),
        .busy_o(busy1), .valid_o(valid1), .col_o(col1), .row_o(row1),
        .chan_o(chan1), .last_o(last1), .row_wrap_o(rw1), .done_o(done1)
    );

    cnn_window_counter #(.width_p(W), .col_stride_p(2), .row_stride_p(1)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .start_i(start),
        .cfg_cols_i(cols), .cfg_rows_i(rows), .cfg_chans_i(chans), .en_i(en),
        .busy_o(busy2), .valid_o(valid2), .col_o(col2), .row_o(row2),
        .chan_o(chan2), .last_o(last2), .row_wrap_o(rw2), .done_o(done2)
    );

    function automatic vec_t mk(input logic r, s, e, input int c, rr, ch,
                                input logic b, input int ec, er, ech,
                                input logic l, w, d);
        vec_t v;
        v.rst = r; v.start = s; v.en = e;
        v.cols = 8'(c); v.rows = 8'(rr); v.chans = 8'(ch);
        v.busy = b; v.col = 8'(ec); v.row = 8'(er); v.chan = 8'(ech);
        v.last = l; v.rw = w; v.done = d;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic b, input int c, r, ch,
                        input logic l, w, d);
        chk({tag, ".busy"},  busy1,  b);
        chk({tag, ".valid"}, valid1, b);
        chk({tag, ".col"},   col1,   c);
        chk({tag, ".row"},   row1,   r);
        chk({tag, ".chan"},  chan1,  ch);
        chk({tag, ".last"},  last1,  l);
        chk({tag, ".rwrap"}, rw1,    w);
        chk({tag, ".done"},  done1,  d);
    endtask

    // One 3x2x2 pass on dut1 checked against an independent tuple-number
    // model. stall selects en pattern 1,0,0,1; hold_start keeps start high
    // and switches cfg to 2x1x1 mid-pass. Returns cycles from first to done.
    task automatic run_3x2x2(input string tag, input bit stall, input bit hold_start,
                             output int cycles);
        int  t;
        bit  fin;
        logic e;
        rst = 0; start = 1; en = 1; cols = 3; rows = 2; chans = 2;
        step();
        chk1({tag, ".first"}, 1, 0, 0, 0, 0, 0, 0);
        start = hold_start;
        t = 0; fin = 0; cycles = 0;
        for (int k = 0; k < 60 && !fin; k++) begin
            e = stall ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            en = e;
            if (hold_start && k == 5) begin
                cols = 2; rows = 1; chans = 1;
            end
            step();
            cycles++;
            if (e) t++;
            if (t == 12) begin
                chk1({tag, ".done"}, 0, 0, 0, 0, 0, 1, 1);
                fin = 1;
            end else begin
                chk1({tag, ".tup"}, 1, t % 3, (t / 3) % 2, t / 6, t == 11,
                     e && (t % 3 == 0), 0);
            end
        end
        if (!fin) chk({tag, ".timeout"}, 0, 1);
    endtask

    vec_t tbl[$];

    initial begin
        int cyc;
        int rw_cnt;
        rst = 1; start = 0; en = 0; cols = 0; rows = 0; chans = 0;

        // reset, reset beats start, T1 full pass
        tbl.push_back(mk(1,0,0, 0,0,0, 0, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,1, 3,2,2, 0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,1, 3,2,2, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 1,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 2,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 1,1,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 2,1,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 0,0,1, 0,1,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 1,0,1, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 2,0,1, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 0,1,1, 0,1,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 1,1,1, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 2,1,1, 1,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 0, 0,0,0, 0,1,1));
        tbl.push_back(mk(0,0,1, 3,2,2, 0, 0,0,0, 0,0,0));
        // T5: zero row bound
        tbl.push_back(mk(0,1,1, 3,0,2, 0, 0,0,0, 0,0,1));
        tbl.push_back(mk(0,0,1, 3,0,2, 0, 0,0,0, 0,0,0));
        // T6: reset at (1,1,0), then restart
        tbl.push_back(mk(0,1,1, 3,2,2, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 1,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 2,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 1,1,0, 0,0,0));
        tbl.push_back(mk(1,0,1, 3,2,2, 0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,1, 3,2,2, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,1, 3,2,2, 1, 1,0,0, 0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; start = tbl[i].start; en = tbl[i].en;
            cols = tbl[i].cols; rows = tbl[i].rows; chans = tbl[i].chans;
            step();
            chk1($sformatf("vec%0d", i), tbl[i].busy, tbl[i].col, tbl[i].row,
                 tbl[i].chan, tbl[i].last, tbl[i].rw, tbl[i].done);
        end

        // T3: stalls
        rst = 1; start = 0; en = 0; step(); rst = 0;
        run_3x2x2("t3", 1'b1, 1'b0, cyc);
        chk("t3.cycles", cyc, 24);
        start = 0; step();
        chk1("t3.idle", 0, 0, 0, 0, 0, 0, 0);

        // T4: start held high, cfg changed mid-pass
        run_3x2x2("t4", 1'b0, 1'b1, cyc);
        chk("t4.cycles", cyc, 12);
        step();
        chk1("t4.p2a", 1, 0, 0, 0, 0, 0, 0);
        start = 0;
        step();
        chk1("t4.p2b", 1, 1, 0, 0, 1, 0, 0);
        step();
        chk1("t4.p2done", 0, 0, 0, 0, 0, 1, 1);
        step();
        chk1("t4.idle", 0, 0, 0, 0, 0, 0, 0);

        // T2: column stride 2 on dut2
        rst = 1; step(); rst = 0;
        start = 1; en = 1; cols = 5; rows = 1; chans = 1;
        rw_cnt = 0;
        step(); start = 0;
        chk("t2.busy0", busy2, 1); chk("t2.col0", col2, 0); chk("t2.last0", last2, 0);
        rw_cnt += rw2;
        step();
        chk("t2.col1", col2, 2); chk("t2.last1", last2, 0);
        rw_cnt += rw2;
        step();
        chk("t2.col2", col2, 4); chk("t2.row2", row2, 0); chk("t2.chan2", chan2, 0);
        chk("t2.last2", last2, 1);
        rw_cnt += rw2;
        step();
        chk("t2.done", done2, 1); chk("t2.rwrap", rw2, 1);
        chk("t2.busy3", busy2, 0); chk("t2.valid3", valid2, 0);
        rw_cnt += rw2;
        step();
        chk("t2.done_pulse", done2, 0);
        rw_cnt += rw2;
        chk("t2.rw_count", rw_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
